// File: rtl/accum_pkg.sv
// Shared defaults and FSM state encoding for the accumulator readout block.
package accum_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned NUM_BUF_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StCapture = 3'd2,
        StOutput  = 3'd3,
        StDone    = 3'd4
    } accum_state_e;

endpackage

// File: rtl/accum_buffer.sv
// Accumulation buffer: adds wr_data_i on each write_en_i; read data appears one cycle after
// rd_en_i and is zero otherwise.
module accum_buffer
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              write_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (clr_i) begin
                acc_q <= '0;
            end else if (write_en_i) begin
                acc_q <= acc_q + wr_data_i;
            end
            rd_data_q <= rd_en_i ? acc_q : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/accum_readout.sv
// Drains NUM_BUF accumulation buffers one at a time onto a valid/ready result port.
// Build macro ACCUM_READOUT_RELU_EN clamps negative captured values to zero.
module accum_readout
    import accum_pkg::*;
#(
    parameter int unsigned NUM_BUF = NUM_BUF_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             acc_wr_active_i,
    output logic [NUM_BUF-1:0]               rd_en_o,
    input  logic [NUM_BUF-1:0][DATA_W-1:0]   buf_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_W-1:0]                out_data_o,
    output logic [$clog2(NUM_BUF)-1:0]       out_idx_o,
    output logic                             out_last_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int unsigned      IDX_W    = $clog2(NUM_BUF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUF - 1);

    accum_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] cap_data;

    assign sel_data = buf_data_i[idx_q];

    always_comb begin
`ifdef ACCUM_READOUT_RELU_EN
        cap_data = sel_data[DATA_W-1] ? '0 : sel_data;
`else
        cap_data = sel_data;
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = StIssue;
                end
            end
            // A buffer write in flight would race the read, so the read waits it out.
            StIssue: begin
                if (!acc_wr_active_i) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                data_d     = cap_data;
                out_idx_d  = idx_q;
                out_last_d = (idx_q == LAST_IDX);
                state_d    = StOutput;
            end
            StOutput: begin
                if (out_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            data_q     <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        rd_en_o = '0;
        if (state_q == StIssue && !acc_wr_active_i) begin
            rd_en_o[idx_q] = 1'b1;
        end
    end

    assign out_valid_o = (state_q == StOutput);
    assign out_data_o  = data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_accum_readout.sv
// Scoreboard bench for accum_readout driving four accum_buffer responders.
// Expected values follow the ACCUM_READOUT_RELU_EN build macro when it is defined.
module tb_accum_readout;

    localparam int unsigned NB = 4;
    localparam int unsigned DW = 32;

`ifdef ACCUM_READOUT_RELU_EN
    localparam logic [DW-1:0] EXP_NEG2 = 32'h0000_0000;
`else
    localparam logic [DW-1:0] EXP_NEG2 = 32'hFFFF_FFFE;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic          last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                buf_rst;
    logic                start;
    logic                out_ready;
    logic                clr;
    logic                acc_wr_active;
    logic [NB-1:0]       rd_en;
    logic [NB-1:0]       wr_en;
    logic [NB-1:0][DW-1:0] wr_data;
    logic [NB-1:0][DW-1:0] buf_data;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [1:0]          out_idx;
    logic                out_last;
    logic                busy;
    logic                done;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   d0;

    always #5 clk = ~clk;

    assign acc_wr_active = |wr_en;

    accum_readout #(.NUM_BUF(NB), .DATA_W(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .acc_wr_active_i(acc_wr_active),
        .rd_en_o        (rd_en),
        .buf_data_i     (buf_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_idx_o      (out_idx),
        .out_last_o     (out_last),
        .busy_o         (busy),
        .done_o         (done)
    );

    for (genvar g = 0; g < NB; g++) begin : g_buf
        accum_buffer #(.DATA_W(DW)) u_buf (
            .clk_i     (clk),
            .rst_i     (buf_rst),
            .clr_i     (clr),
            .write_en_i(wr_en[g]),
            .wr_data_i (wr_data[g]),
            .rd_en_i   (rd_en[g]),
            .rd_data_o (buf_data[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int b, input logic [DW-1:0] v);
        wr_en[b]   = 1'b1;
        wr_data[b] = v;
        tick();
        wr_en[b]   = 1'b0;
    endtask

    task automatic clear_bufs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [1:0] i);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.last = (i == 2'd3);
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_rd(input int b, input int budget);
        int n;
        n = 0;
        while (!rd_en[b] && n < budget) begin
            tick();
            n++;
        end
        check("wait_rd", rd_en[b], 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_idx"}, out_idx, 0);
        check({tag, "_last"}, out_last, 0);
    endtask

    task automatic monitor();
        exp_t          e;
        logic          stall_prev;
        logic          exp_done;
        logic          legal;
        logic [DW-1:0] pd;
        logic [1:0]    pi;
        stall_prev = 1'b0;
        exp_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                exp_done   = 1'b0;
                continue;
            end
            legal = $onehot0(rd_en) &&
                    !((|rd_en) && (out_valid || !busy || acc_wr_active));
            check("rd_en_legal", legal, 1);
            if (done) done_cnt++;
            if (exp_done || done) check("done_after_last", done, exp_done);
            exp_done = 1'b0;
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, pd);
                check("stall_idx", out_idx, pi);
            end
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", out_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", out_idx, e.idx);
                    check("out_last", out_last, e.last);
                    exp_done = e.last;
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        buf_rst   = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        wr_en     = '0;
        wr_data   = '0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst     = 1'b0;
        buf_rst = 1'b0;

        // Basic drain with latency checks.
        load(0, 32'd5);
        load(0, 32'd7);
        load(1, 32'd100);
        load(2, 32'd0);
        load(3, 32'hFFFF_FFFD);
        load(3, 32'd1);
        push(32'd12, 2'd0);
        push(32'd100, 2'd1);
        push(32'd0, 2'd2);
        push(EXP_NEG2, 2'd3);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_rd_en0", rd_en, 4'b0001);
        check("lat_busy", busy, 1);
        tick();
        check("lat_valid_n2", out_valid, 0);
        tick();
        check("lat_valid_n3", out_valid, 1);
        wait_idle("basic_timeout", 40);
        check("basic_sb_empty", sb_q.size(), 0);
        check("basic_done_cnt", done_cnt - d0, 1);

        // Backpressure for 10 cycles on idx 1.
        clear_bufs();
        load(0, 32'd10);
        load(1, 32'd20);
        load(2, 32'd30);
        load(3, 32'd40);
        push(32'd10, 2'd0);
        push(32'd20, 2'd1);
        push(32'd30, 2'd2);
        push(32'd40, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rd(1, 20);
        out_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", out_valid, 1);
            check("bp_idx", out_idx, 1);
            check("bp_data", out_data, 32'd20);
            check("bp_rd_en", rd_en, 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("bp_timeout", 40);
        check("bp_sb_empty", sb_q.size(), 0);

        // Writes active for 4 cycles while ISSUE holds idx 0.
        clear_bufs();
        load(0, 32'd50);
        load(1, 32'd6);
        load(2, 32'd7);
        load(3, 32'd8);
        push(32'd54, 2'd0);
        push(32'd6, 2'd1);
        push(32'd7, 2'd2);
        push(32'd8, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en[0]   = 1'b1;
        wr_data[0] = 32'd1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("gate_rd_en", rd_en, 0);
            tick();
        end
        wr_en[0] = 1'b0;
        #1;
        check("gate_release", rd_en, 4'b0001);
        wait_idle("gate_timeout", 40);
        check("gate_sb_empty", sb_q.size(), 0);

        // start pulses during a drain and during DONE are ignored.
        clear_bufs();
        load(0, 32'd1);
        load(1, 32'd2);
        load(2, 32'd3);
        load(3, 32'd4);
        push(32'd1, 2'd0);
        push(32'd2, 2'd1);
        push(32'd3, 2'd2);
        push(32'd4, 2'd3);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rd(2, 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 30) begin
                tick();
                n++;
            end
        end
        check("restart_done_seen", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("restart_busy", busy, 0);
        check("restart_sb_empty", sb_q.size(), 0);
        check("restart_done_cnt", done_cnt - d0, 1);

        // Reset while idx 2 is held in OUTPUT, then restart on the first edge after release.
        clear_bufs();
        load(0, 32'd11);
        load(1, 32'd22);
        load(2, 32'd33);
        load(3, 32'd44);
        push(32'd11, 2'd0);
        push(32'd22, 2'd1);
        push(32'd33, 2'd2);
        push(32'd44, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rd(2, 20);
        out_ready = 1'b0;
        tick();
        tick();
        check("prerst_valid", out_valid, 1);
        check("prerst_idx", out_idx, 2);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        sb_q.delete();
        tick();
        tick();
        push(32'd11, 2'd0);
        push(32'd22, 2'd1);
        push(32'd33, 2'd2);
        push(32'd44, 2'd3);
        d0 = done_cnt;
        rst       = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("postrst_rd_en0", rd_en, 4'b0001);
        wait_idle("postrst_timeout", 40);
        check("postrst_sb_empty", sb_q.size(), 0);
        check("postrst_done_cnt", done_cnt - d0, 1);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
